// File: rtl/iddr_deser.sv
// rtl/iddr_deser.sv - multi-channel IDDR pair deserializer with per-lane bitslip and inversion
module iddr_deser #(
  parameter int                    CHANNELS  = 4,
  parameter int                    WORD_BITS = 8,
  parameter logic [CHANNELS-1:0]   INV_MASK  = '0
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            CE,
  input  logic                            SYNC,
  input  logic [CHANNELS-1:0]             D_RISE,
  input  logic [CHANNELS-1:0]             D_FALL,
  input  logic [CHANNELS-1:0]             BITSLIP,
  output logic [CHANNELS*WORD_BITS-1:0]   DATA,
  output logic                            VALID,
  output logic [CHANNELS*5-1:0]           SLIP_POS
);

  localparam int HALF   = WORD_BITS / 2;
  localparam int SR_W   = 2 * WORD_BITS;
  localparam int CW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SW     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(WORD_BITS - 1);

  logic [SR_W-1:0]                  sr_q   [CHANNELS];
  logic [SR_W-1:0]                  sr_d   [CHANNELS];
  logic [SW-1:0]                    s_q    [CHANNELS];
  logic [SW-1:0]                    s_d    [CHANNELS];
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [CHANNELS*WORD_BITS-1:0]    data_q, data_d;
  logic                             valid_q, valid_d;
  logic [CHANNELS-1:0]              r, f;
  logic                             emit;
  logic [SR_W-1:0]                  win;

  assign r    = D_RISE ^ INV_MASK;
  assign f    = D_FALL ^ INV_MASK;
  // SYNC steals the word boundary, so a SYNC edge can never emit.
  assign emit = CE && !SYNC && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = emit;
    win     = '0;
    if (SYNC)
      cnt_d = '0;
    else if (CE)
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    for (int c = 0; c < CHANNELS; c++) begin
      sr_d[c] = CE ? {sr_q[c][SR_W-3:0], r[c], f[c]} : sr_q[c];
      s_d[c]  = s_q[c];
      if (BITSLIP[c])
        s_d[c] = (s_q[c] == S_LAST) ? '0 : s_q[c] + SW'(1);
      // Larger offsets pick a window further back in the bit history.
      win = sr_d[c] >> s_q[c];
      if (emit)
        data_d[c*WORD_BITS +: WORD_BITS] = win[WORD_BITS-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        sr_q[c] <= '0;
        s_q[c]  <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      for (int c = 0; c < CHANNELS; c++) begin
        sr_q[c] <= sr_d[c];
        s_q[c]  <= s_d[c];
      end
    end
  end

  assign DATA  = data_q;
  assign VALID = valid_q;

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_slip
      assign SLIP_POS[g*5 +: 5] = 5'(s_q[g]);
    end
  endgenerate

endmodule

// File: tb/tb_iddr_deser.sv
// tb/tb_iddr_deser.sv - directed self-checking bench for iddr_deser
module tb_iddr_deser;
  localparam int CH = 4;
  localparam int WB = 8;

  logic              CLK = 1'b0;
  logic              RST_N, CE, SYNC;
  logic [CH-1:0]     D_RISE, D_FALL, BITSLIP;
  logic [CH*WB-1:0]  DATA;
  logic              VALID;
  logic [CH*5-1:0]   SLIP_POS;

  int checks = 0;
  int errors = 0;
  int idx = 0;
  logic [7:0] pat = 8'hB2;

  always #5 CLK = ~CLK;

  iddr_deser #(.CHANNELS(CH), .WORD_BITS(WB), .INV_MASK(4'b0010)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .SYNC(SYNC),
    .D_RISE(D_RISE), .D_FALL(D_FALL), .BITSLIP(BITSLIP),
    .DATA(DATA), .VALID(VALID), .SLIP_POS(SLIP_POS)
  );

  function automatic logic sbit(input int p);
    return pat[7 - (p % 8)];
  endfunction

  function automatic logic [WB-1:0] lane(input int c);
    return DATA[c*WB +: WB];
  endfunction

  function automatic logic [4:0] spos(input int c);
    return SLIP_POS[c*5 +: 5];
  endfunction

  task automatic step(input logic ce, input logic sync, input logic [CH-1:0] slip);
    CE = ce; SYNC = sync; BITSLIP = slip;
    if (ce) begin
      D_RISE = {CH{sbit(2*idx)}};
      D_FALL = {CH{sbit(2*idx+1)}};
      idx++;
    end else begin
      D_RISE = CH'($urandom);
      D_FALL = CH'($urandom);
    end
    @(posedge CLK); #1;
    CE = 1'b0; SYNC = 1'b0; BITSLIP = '0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; CE = 1'b0; SYNC = 1'b0; BITSLIP = '0; D_RISE = '0; D_FALL = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    idx = 0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CE = 1'b0; SYNC = 1'b0; BITSLIP = '0; D_RISE = '0; D_FALL = '0;
    #2;
    checks++; if (DATA !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", DATA); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", VALID); end
    checks++; if (SLIP_POS !== '0) begin errors++; $display("FAIL reset_slip got %h exp 0", SLIP_POS); end
    do_reset();
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %b exp 0", VALID); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b1, 1'b0, '0);
        checks++;
        if (VALID !== (k == 3)) begin errors++; $display("FAIL basic_valid w%0d k%0d got %b exp %b", w, k, VALID, (k == 3)); end
        if (k == 3) begin
          checks++;
          if (lane(0) !== 8'hB2) begin errors++; $display("FAIL basic_data got %h exp b2", lane(0)); end
        end
      end
    end
  endtask

  task automatic test_inversion();
    logic [7:0] exp;
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, '0);
    for (int c = 0; c < CH; c++) begin
      exp = (c == 1) ? 8'h4D : 8'hB2;
      checks++;
      if (lane(c) !== exp) begin errors++; $display("FAIL inv_lane%0d got %h exp %h", c, lane(c), exp); end
    end
  endtask

  task automatic test_bitslip();
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 4'b0001);
    checks++; if (spos(0) !== 5'd1) begin errors++; $display("FAIL slip_pos1 got %0d exp 1", spos(0)); end
    checks++; if (spos(1) !== 5'd0) begin errors++; $display("FAIL slip_other got %0d exp 0", spos(1)); end
    for (int k = 1; k < 4; k++) step(1'b1, 1'b0, '0);
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL slip_valid got %b exp 1", VALID); end
    checks++; if (lane(0) !== 8'h59) begin errors++; $display("FAIL slip_data got %h exp 59", lane(0)); end
    checks++; if (lane(2) !== 8'hB2) begin errors++; $display("FAIL slip_unslipped got %h exp b2", lane(2)); end
    for (int n = 0; n < 7; n++) begin
      step(1'b1, 1'b0, 4'b0001);
      checks++;
      if (spos(0) !== 5'((2 + n) % 8)) begin errors++; $display("FAIL slip_count n%0d got %0d exp %0d", n, spos(0), (2 + n) % 8); end
    end
    step(1'b1, 1'b0, '0);
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL slip_wrap_valid got %b exp 1", VALID); end
    checks++; if (lane(0) !== 8'hB2) begin errors++; $display("FAIL slip_wrap_data got %h exp b2", lane(0)); end
  endtask

  task automatic test_ce_gaps();
    int gaps [8] = '{0, 2, 1, 3, 1, 0, 2, 1};
    logic [7:0] held;
    do_reset();
    held = 8'h00;
    for (int n = 0; n < 8; n++) begin
      for (int g = 0; g < gaps[n]; g++) begin
        step(1'b0, 1'b0, '0);
        checks++;
        if (VALID !== 1'b0 || lane(0) !== held) begin
          errors++; $display("FAIL gap_hold n%0d got v=%b d=%h exp v=0 d=%h", n, VALID, lane(0), held);
        end
      end
      step(1'b1, 1'b0, '0);
      checks++;
      if (VALID !== (n % 4 == 3)) begin errors++; $display("FAIL gap_valid n%0d got %b exp %b", n, VALID, (n % 4 == 3)); end
      if (n % 4 == 3) begin
        held = 8'hB2;
        checks++;
        if (lane(0) !== 8'hB2) begin errors++; $display("FAIL gap_data n%0d got %h exp b2", n, lane(0)); end
      end
    end
  endtask

  task automatic test_sync();
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, '0);
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL sync_edge_valid got %b exp 0", VALID); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if (VALID !== (k == 3)) begin errors++; $display("FAIL sync_valid k%0d got %b exp %b", k, VALID, (k == 3)); end
    end
    checks++; if (lane(0) !== 8'hAC) begin errors++; $display("FAIL sync_data got %h exp ac", lane(0)); end
    checks++; if (lane(1) !== 8'h53) begin errors++; $display("FAIL sync_data_inv got %h exp 53", lane(1)); end
  endtask

  task automatic test_reset_midword();
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b0, '0);
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (DATA !== '0) begin errors++; $display("FAIL mid_reset_data got %h exp 0", DATA); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", VALID); end
    checks++; if (SLIP_POS !== '0) begin errors++; $display("FAIL mid_reset_slip got %h exp 0", SLIP_POS); end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if (VALID !== (k == 3)) begin errors++; $display("FAIL mid_release_valid k%0d got %b exp %b", k, VALID, (k == 3)); end
    end
    checks++; if (lane(0) !== 8'hB2) begin errors++; $display("FAIL mid_release_data got %h exp b2", lane(0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inversion();
    test_bitslip();
    test_ce_gaps();
    test_sync();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iddr_deser.md
Name:
iddr_deser

Overview:
- Parametrised multi-channel DDR input deserializer.
- Takes the rise/fall bit pairs produced by per-pin IDDR primitives and assembles them into WORD_BITS-wide parallel words for each channel.
- Provides per-channel bitslip for word alignment, per-channel polarity inversion, and a shared frame strobe.
- Sits between the IDDR capture stage and receiver logic, e.g. 8b10b decoders or FE data framers.

Parameters:
- CHANNELS, 4, number of independent serial lanes (1..32).
- WORD_BITS, 8, output word width per channel; even, 2..32; one word takes WORD_BITS/2 CE cycles.
- INV_MASK, 0, CHANNELS-bit mask; bit c=1 inverts both D_RISE[c] and D_FALL[c] before use.

Ports:
- CLK  in  1  deserializer clock, same clock as the IDDR outputs.
- RST_N  in  1  asynchronous active-low reset.
- CE  in  1  pair-valid strobe; one rise/fall pair per channel is consumed on each CLK edge with CE=1.
- SYNC  in  1  synchronous frame restart; forces the frame counter to 0.
- D_RISE  in  CHANNELS  per-channel bit captured on the rising edge (earlier in time).
- D_FALL  in  CHANNELS  per-channel bit captured on the falling edge (later in time).
- BITSLIP  in  CHANNELS  per-channel slip request, one slip per cycle asserted.
- DATA  out  CHANNELS*WORD_BITS  channel c occupies DATA[c*WORD_BITS +: WORD_BITS]; MSB is the earliest bit in time.
- VALID  out  1  one-cycle strobe; DATA is new and stable while VALID=1.
- SLIP_POS  out  CHANNELS*5  current slip offset per channel (0..WORD_BITS-1), zero-extended to 5 bits.

Behaviour:
- Reset (RST_N=0, asynchronous) clears:
  - shift registers
  - frame counter (cnt)
  - slip offsets
  - DATA (to 0)
  - VALID (to 0)
- Release from reset is synchronous to CLK.
- Input conditioning: r = D_RISE ^ INV_MASK, f = D_FALL ^ INV_MASK.
- Per channel, a shift register sr[2*WORD_BITS-1:0] holds the bit history:
  - On CE=1: sr <= {sr[2*WORD_BITS-3:0], r[c], f[c]}, so the newest bit is at LSB and r precedes f in time.
  - On CE=0: sr holds.
- Frame counter cnt, width clog2(WORD_BITS/2), shared by all channels:
  - On CE=1: if cnt==WORD_BITS/2-1, cnt <= 0, else cnt <= cnt+1.
  - On CE=0: cnt holds.
- Word output, per channel with sr' = the shift register value including the current pair:
  - On an edge with CE=1 and cnt==WORD_BITS/2-1, DATA_c <= sr'[s+WORD_BITS-1 : s], where s is that channel's slip offset.
  - VALID <= 1 on that edge, else VALID <= 0.
  - DATA holds between VALID strobes.
  - Latency: the word appears on the edge that captures its last pair; the last bit entering DATA is the most recent f when s=0.
- Bitslip:
  - BITSLIP[c]=1 on an edge sets s_c <= (s_c==WORD_BITS-1) ? 0 : s_c+1. This wraps, and is independent of CE and cnt.
  - Each +1 shifts the selected window one bit older in time.
  - The new offset applies from the next word.
  - Holding BITSLIP high for N cycles gives N slips.
- SYNC:
  - SYNC=1 sets cnt <= 0 on that edge and has priority over the CE increment.
  - If SYNC and CE are both 1, the pair is still shifted into sr, but no VALID is produced that cycle.
  - SYNC does not clear sr, DATA or s.
- CE low mid-word: the word is simply stretched; VALID is never produced on a CE=0 cycle.
- Reset mid-word: the partial word is discarded and the first VALID comes after WORD_BITS/2 CE cycles from release.
- Channels differ only in sr and s; VALID is common to all channels.

Test Plan:
- Basic frame, CHANNELS=1, WORD_BITS=8, CE=1 constant: pairs (1,0),(1,1),(0,0),(1,0) -> VALID on the 4th edge, DATA=0xB2, then VALID=0 for 3 cycles; a repeating stream gives 0xB2 every 4 cycles.
- Bitslip, same stream: one BITSLIP pulse -> SLIP_POS=1, next word=0x59 (window one bit older); 8 pulses total -> SLIP_POS wraps to 0 and DATA returns to 0xB2.
- Inversion, INV_MASK=4'b0010 with CHANNELS=4 and all lanes fed the 0xB2 stream -> lane 1 DATA=0x4D, lanes 0/2/3 DATA=0xB2.
- CE gaps: insert CE=0 cycles between pairs -> same DATA values, VALID only on CE=1 edges, interval equals 4 CE cycles.
- SYNC: assert SYNC with CE=1 at cnt=2 -> no VALID that cycle; the next VALID occurs exactly 4 CE edges later, and the window is realigned by 3 pairs.
- Reset mid-word: drop RST_N asynchronously after 2 pairs -> DATA=0, VALID=0, SLIP_POS=0 immediately; after release the first VALID comes on the 4th CE edge.
